// File: rtl/resp_fifo_arb.sv
// Two-requester response arbiter feeding a downstream FIFO. Bursts lock the
// owner until its last beat; otherwise grants round-robin between requesters.
module resp_fifo_arb #(
    parameter int unsigned DW    = 34,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CW    = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          s0_valid,
    input  logic [DW-1:0] s0_data,
    input  logic          s0_last,
    output logic          s0_ready,
    input  logic          s1_valid,
    input  logic [DW-1:0] s1_data,
    input  logic          s1_last,
    output logic          s1_ready,
    output logic          fifo_we,
    output logic [DW-1:0] fifo_din,
    input  logic          fifo_re,
    output logic [CW-1:0] occ,
    output logic          grant_id,
    output logic          busy,
    output logic          err
);

    typedef enum logic {StArb, StHold} state_e;

    state_e        state_q, state_d;
    logic          last_grant_q, last_grant_d;
    logic          owner_q, owner_d;
    logic [CW-1:0] occ_q, occ_d;
    logic          grant_id_q, grant_id_d;
    logic          err_q, err_d;

    logic space;
    logic sel;
    logic sel_any;
    logic sel_valid;
    logic sel_last;
    logic grant_ok;
    logic accept;

    // Grant selection: owner is locked in HOLD, round-robin on contention in ARB.
    always_comb begin
        sel     = 1'b0;
        sel_any = 1'b0;
        if (state_q == StHold) begin
            sel     = owner_q;
            sel_any = 1'b1;
        end else if (s0_valid && s1_valid) begin
            sel     = ~last_grant_q;
            sel_any = 1'b1;
        end else if (s0_valid) begin
            sel     = 1'b0;
            sel_any = 1'b1;
        end else if (s1_valid) begin
            sel     = 1'b1;
            sel_any = 1'b1;
        end
    end

    always_comb begin
        space     = (occ_q < CW'(DEPTH));
        grant_ok  = rst & space & sel_any;
        s0_ready  = grant_ok & ~sel;
        s1_ready  = grant_ok & sel;
        sel_valid = sel ? s1_valid : s0_valid;
        sel_last  = sel ? s1_last : s0_last;
        accept    = grant_ok & sel_valid;
        fifo_we   = accept;
        fifo_din  = (accept && sel) ? s1_data : s0_data;
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        occ_d        = occ_q;
        grant_id_d   = grant_id_q;
        err_d        = err_q;

        if (accept) begin
            grant_id_d = sel;
            if (state_q == StArb) begin
                if (sel_last) begin
                    last_grant_d = sel;
                end else begin
                    state_d = StHold;
                    owner_d = sel;
                end
            end else if (sel_last) begin
                state_d      = StArb;
                last_grant_d = owner_q;
            end
        end

        // A pop on an empty FIFO with a simultaneous write is a pass-through.
        if (accept && !fifo_re) begin
            occ_d = occ_q + CW'(1);
        end else if (fifo_re && !accept) begin
            if (occ_q != '0) begin
                occ_d = occ_q - CW'(1);
            end else begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= StArb;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            occ_q        <= '0;
            grant_id_q   <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            occ_q        <= occ_d;
            grant_id_q   <= grant_id_d;
            err_q        <= err_d;
        end
    end

    assign occ      = occ_q;
    assign grant_id = grant_id_q;
    assign busy     = (state_q == StHold);
    assign err      = err_q;

endmodule

// File: tb/tb_resp_fifo_arb.sv
// Directed bench for resp_fifo_arb: expected writes go into a scoreboard queue
// that a negedge monitor drains against fifo_we/fifo_din.
module tb_resp_fifo_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic        s0_valid, s0_last, s0_ready;
    logic        s1_valid, s1_last, s1_ready;
    logic [33:0] s0_data, s1_data;
    logic        fifo_we, fifo_re;
    logic [33:0] fifo_din;
    logic [2:0]  occ;
    logic        grant_id, busy, err;

    int          n_chk  = 0;
    int          n_fail = 0;
    int          tag    = 0;
    logic [33:0] exp_q[$];

    always #5 clk = ~clk;

    resp_fifo_arb #(.DW(34), .DEPTH(4), .CW(3)) dut (
        .clk      (clk),
        .rst      (rst),
        .s0_valid (s0_valid),
        .s0_data  (s0_data),
        .s0_last  (s0_last),
        .s0_ready (s0_ready),
        .s1_valid (s1_valid),
        .s1_data  (s1_data),
        .s1_last  (s1_last),
        .s1_ready (s1_ready),
        .fifo_we  (fifo_we),
        .fifo_din (fifo_din),
        .fifo_re  (fifo_re),
        .occ      (occ),
        .grant_id (grant_id),
        .busy     (busy),
        .err      (err)
    );

    function automatic logic [33:0] d0(input int t);
        logic [31:0] tt;
        tt = t;
        return {2'b00, 16'hA0A0, tt[15:0]};
    endfunction

    function automatic logic [33:0] d1(input int t);
        logic [31:0] tt;
        tt = t;
        return {2'b01, 16'hB1B1, tt[15:0]};
    endfunction

    task automatic check(input string name, input logic [33:0] got, input logic [33:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic drive(input logic v0, input logic l0, input logic v1, input logic l1,
                         input logic re);
        tag++;
        s0_valid = v0;
        s0_last  = l0;
        s0_data  = d0(tag);
        s1_valid = v1;
        s1_last  = l1;
        s1_data  = d1(tag);
        fifo_re  = re;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every write must match the head of the scoreboard, and every
    // expected write must appear in the cycle it was queued for.
    always @(negedge clk) begin
        if (fifo_we) begin
            n_chk++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write: got din %0h, expected no write", fifo_din);
            end else begin
                logic [33:0] e;
                e = exp_q.pop_front();
                if (fifo_din !== e) begin
                    n_fail++;
                    $display("FAIL write_data: got %0h, expected %0h", fifo_din, e);
                end
            end
        end else if (exp_q.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL missed_write: got no write, expected %0h", exp_q[0]);
            exp_q.delete();
        end
    end

    initial begin
        rst = 1'b0;
        drive(1, 1, 1, 1, 1);
        @(negedge clk);
        check("rst_s0_ready", s0_ready, 0);
        check("rst_s1_ready", s1_ready, 0);
        check("rst_fifo_we", fifo_we, 0);
        tick();
        @(negedge clk);
        check("rst_occ", occ, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        check("rst_grant_id", grant_id, 0);
        tick();
        rst = 1'b1;

        // Round-robin fill: s0,s1,s0,s1 then full.
        for (int k = 0; k < 4; k++) begin
            drive(1, 1, 1, 1, 0);
            exp_q.push_back((k % 2 == 0) ? d0(tag) : d1(tag));
            @(negedge clk);
            check("fill_occ", occ, k);
            check("fill_s0_ready", s0_ready, (k % 2 == 0));
            check("fill_s1_ready", s1_ready, (k % 2 == 1));
            tick();
        end
        drive(1, 1, 1, 1, 0);
        @(negedge clk);
        check("full_occ", occ, 4);
        check("full_s0_ready", s0_ready, 0);
        check("full_s1_ready", s1_ready, 0);
        check("full_grant_id", grant_id, 1);
        tick();

        // Full with pop: no bypass write, then write next cycle.
        drive(1, 1, 0, 1, 1);
        @(negedge clk);
        check("nobypass_occ", occ, 4);
        check("nobypass_s0_ready", s0_ready, 0);
        tick();
        drive(1, 1, 0, 1, 1);
        exp_q.push_back(d0(tag));
        @(negedge clk);
        check("after_pop_occ", occ, 3);
        check("after_pop_s0_ready", s0_ready, 1);
        tick();
        for (int j = 3; j >= 1; j--) begin
            drive(0, 1, 0, 1, 1);
            @(negedge clk);
            check("drain_occ", occ, j);
            tick();
        end
        drive(0, 1, 1, 1, 1);
        exp_q.push_back(d1(tag));
        @(negedge clk);
        check("passthru_occ", occ, 0);
        tick();

        // s0 burst of 3 with s1 contending, popping every cycle.
        for (int b = 0; b < 3; b++) begin
            drive(1, (b == 2), 1, 1, 1);
            exp_q.push_back(d0(tag));
            @(negedge clk);
            check("burst_busy", busy, (b != 0));
            check("burst_s1_ready", s1_ready, 0);
            check("burst_occ", occ, 0);
            check("burst_err", err, 0);
            tick();
        end
        drive(0, 1, 1, 1, 1);
        exp_q.push_back(d1(tag));
        @(negedge clk);
        check("post_burst_busy", busy, 0);
        check("post_burst_s1_ready", s1_ready, 1);
        tick();

        // Underflow sets a sticky error.
        drive(0, 1, 0, 1, 1);
        @(negedge clk);
        check("pre_uf_occ", occ, 0);
        check("pre_uf_err", err, 0);
        check("pre_uf_grant_id", grant_id, 1);
        tick();
        drive(0, 1, 0, 1, 0);
        @(negedge clk);
        check("uf_occ", occ, 0);
        check("uf_err", err, 1);
        tick();
        drive(0, 1, 0, 1, 0);
        @(negedge clk);
        check("uf_err_held", err, 1);
        tick();

        rst = 1'b0;
        drive(0, 1, 0, 1, 0);
        tick();
        rst = 1'b1;
        drive(0, 1, 0, 1, 0);
        @(negedge clk);
        check("rst2_err", err, 0);
        check("rst2_occ", occ, 0);
        tick();

        // Open a burst, stall the non-owner, then reset mid-burst.
        drive(1, 0, 0, 1, 0);
        exp_q.push_back(d0(tag));
        @(negedge clk);
        check("hold0_busy", busy, 0);
        tick();
        drive(0, 0, 1, 1, 0);
        @(negedge clk);
        check("hold1_busy", busy, 1);
        check("hold1_s1_ready", s1_ready, 0);
        check("hold1_occ", occ, 1);
        tick();
        drive(1, 0, 1, 1, 0);
        exp_q.push_back(d0(tag));
        @(negedge clk);
        check("hold2_s0_ready", s0_ready, 1);
        check("hold2_s1_ready", s1_ready, 0);
        tick();
        rst = 1'b0;
        drive(1, 0, 1, 1, 0);
        @(negedge clk);
        check("midrst_occ", occ, 2);
        check("midrst_busy", busy, 1);
        check("midrst_s0_ready", s0_ready, 0);
        check("midrst_s1_ready", s1_ready, 0);
        check("midrst_fifo_we", fifo_we, 0);
        tick();
        rst = 1'b1;
        drive(1, 1, 1, 1, 0);
        exp_q.push_back(d0(tag));
        @(negedge clk);
        check("postrst_occ", occ, 0);
        check("postrst_busy", busy, 0);
        check("postrst_grant_id", grant_id, 0);
        check("postrst_s0_ready", s0_ready, 1);
        check("postrst_s1_ready", s1_ready, 0);
        tick();
        drive(0, 1, 0, 1, 0);
        @(negedge clk);
        check("final_occ", occ, 1);
        check("scoreboard_empty", exp_q.size(), 0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
